// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared types and constants for the system-ID check master
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_REQ  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_REQ  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } state_e;

    localparam int ID_OFS  = 0;
    localparam int TS_OFS  = 1;
    localparam int TMR_W   = 8;
    localparam int RETRY_W = 3;

endpackage

// File: rtl/sysid_check_timer.sv
// rtl/sysid_check_timer.sv - load-on-clear read timeout down-counter
module sysid_check_timer
    import sysid_check_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(TIMEOUT_CYC);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    // Reload on entry to a request state, otherwise count down while a read is in flight
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle holding count 1 is the TIMEOUT_CYC-th active cycle since the reload
    assign expired = run && (cnt_q <= TMR_W'(1));

endmodule

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - Avalon-MM read master that checks system ID and build timestamp
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter int          ADDR_W      = 1,
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1339298534,
    parameter int          TIMEOUT_CYC = 255,
    parameter int          MAX_RETRY   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout_err,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    localparam logic [RETRY_W-1:0] MAX_RETRY_L = RETRY_W'(MAX_RETRY);

    state_e               state_q, state_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 pass_q, pass_d;
    logic                 terr_q, terr_d;
    logic [31:0]          id_q, id_d;
    logic [31:0]          ts_q, ts_d;

    logic                 in_req, in_wait, tmr_run, tmr_load, tmr_expired;
    logic                 data_hit, timed_out, can_retry;

    assign in_req    = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
    assign in_wait   = (state_q == ST_ID_WAIT) || (state_q == ST_TS_WAIT);
    assign tmr_run   = in_req || in_wait;
    // Data only counts once the request has been accepted; stale beats elsewhere are dropped
    assign data_hit  = avm_readdatavalid && (in_wait || (in_req && !avm_waitrequest));
    assign timed_out = tmr_expired && !data_hit;
    assign can_retry = retry_q < MAX_RETRY_L;

    sysid_check_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (tmr_load),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a timeout overrides normal progress and restarts at the ID word
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ID_REQ;
            ST_ID_REQ:  if (data_hit) state_d = ST_TS_REQ;
                        else if (!avm_waitrequest) state_d = ST_ID_WAIT;
            ST_ID_WAIT: if (data_hit) state_d = ST_TS_REQ;
            ST_TS_REQ:  if (data_hit) state_d = ST_FINISH;
                        else if (!avm_waitrequest) state_d = ST_TS_WAIT;
            ST_TS_WAIT: if (data_hit) state_d = ST_FINISH;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (timed_out) begin
            state_d = can_retry ? ST_ID_REQ : ST_FINISH;
        end
        tmr_load = ((state_d == ST_ID_REQ) || (state_d == ST_TS_REQ)) &&
                   ((state_d != state_q) || timed_out);
    end

    // Moore outputs decoded from the current state
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_FINISH);
        avm_read    = in_req;
        avm_address = (state_q == ST_TS_REQ) ? ADDR_W'(TS_OFS) : ADDR_W'(ID_OFS);
    end

    // Capture, retry bookkeeping and result flags
    always_comb begin
        retry_d = retry_q;
        pass_d  = pass_q;
        terr_d  = terr_q;
        id_d    = id_q;
        ts_d    = ts_q;
        if ((state_q == ST_IDLE) && start) begin
            retry_d = '0;
            pass_d  = 1'b0;
            terr_d  = 1'b0;
        end
        if (data_hit) begin
            if ((state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT)) begin
                id_d = avm_readdata;
            end else begin
                ts_d = avm_readdata;
            end
        end
        if (timed_out) begin
            if (can_retry) begin
                retry_d = retry_q + 1'b1;
            end else begin
                terr_d = 1'b1;
                pass_d = 1'b0;
            end
        end
        // A timed-out sequence keeps pass low rather than comparing stale words
        if ((state_q == ST_FINISH) && !terr_q) begin
            pass_d = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= '0;
            pass_q  <= 1'b0;
            terr_q  <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            retry_q <= retry_d;
            pass_q  <= pass_d;
            terr_q  <= terr_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    assign pass        = pass_q;
    assign timeout_err = terr_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule
